// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM word, RAM handshake state and memory arbiter state.
// Imported by the arbiter interface, the arbiter itself and its bench.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model/controller for the current strobe.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter FSM: idle, or holding the RAM for the icache or the dcache.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Which requester completed the most recent transaction.
  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } src_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter; the arbiter uses the
// slave modport, the surrounding caches/RAM (or a bench) use the master modport.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // icache port
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // dcache port
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: icache reads and dcache reads/writes share one RAM.
// Ties alternate, starting with the dcache; the winner's request is latched on grant.
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state;
  arb_state_t next_state;
  src_t       last_grant;

  word_t      lat_addr;
  word_t      lat_store;
  logic       lat_ren;
  logic       lat_wen;

  logic       i_req;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       done;

  assign i_req = bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;

  // Next-state: arbitration in IDLE, completion/abort while granted.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (last_grant == SRC_D) grant_i = 1'b1;
          else                     grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end

        if (grant_i)      next_state = GRANT_I;
        else if (grant_d) next_state = GRANT_D;
      end

      // A requester that withdraws aborts the access even if the RAM answers now.
      GRANT_I: begin
        if (!i_req) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          next_state = IDLE;
          done       = 1'b1;
        end
      end

      GRANT_D: begin
        if (!d_req) begin
          next_state = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          next_state = IDLE;
          done       = 1'b1;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // State, fairness history and the latched request.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: the request latches are plain registers (not a memory), so they are reset
    // with the FSM; the RAM never sees stale address/data after a mid-access reset.
    if (!nRST) begin
      state      <= IDLE;
      last_grant <= SRC_I;
      lat_addr   <= '0;
      lat_store  <= '0;
      lat_ren    <= 1'b0;
      lat_wen    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge.
      state <= next_state;

      if (done) begin
        last_grant <= (state == GRANT_D) ? SRC_D : SRC_I;
      end

      if (grant_i) begin
        lat_addr  <= bus.iaddr;
        lat_store <= '0;
        lat_ren   <= 1'b1;
        lat_wen   <= 1'b0;
      end else if (grant_d) begin
        lat_addr  <= bus.daddr;
        lat_store <= bus.dstore;
        lat_ren   <= bus.dREN;
        lat_wen   <= bus.dWEN;
      end
    end
  end

  // Outputs: RAM side driven only from the latches, cache side released on completion.
  always_comb begin
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = lat_addr;
    bus.ramstore = lat_store;

    if (state != IDLE) begin
      bus.ramREN = lat_ren;
      bus.ramWEN = lat_wen;
    end

    if (done && (state == GRANT_I)) begin
      bus.iwait = 1'b0;
      bus.iload = bus.ramload;
    end

    if (done && (state == GRANT_D)) begin
      bus.dwait = 1'b0;
      bus.dload = bus.ramload;
    end
  end

  // The dcache never reads and writes at once, so at most one RAM strobe is driven.
  a_d_onehot: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.dREN && bus.dWEN));
  a_ram_onehot: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.ramREN && bus.ramWEN));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cache drivers push expectations into scoreboard queues,
// a negedge monitor pops them on every completion; a scripted/random RAM answers.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  typedef struct {
    word_t addr;
    word_t data;
  } i_txn_t;

  typedef struct {
    logic  wr;
    word_t addr;
    word_t data;
  } d_txn_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          i_done_cyc;
  int          d_done_cyc;
  i_txn_t      i_q[$];
  d_txn_t      d_q[$];
  logic [7:0]  order_log[$];
  word_t       shadow[word_t];
  word_t       mem[word_t];

  // RAM responder configuration
  bit          rand_mode  = 1'b0;
  bit          force_load = 1'b0;
  word_t       load_cfg   = '0;
  int          busy_cfg   = 0;
  int          err_cfg    = -1;
  bit          ram_active = 1'b0;
  int          ram_left   = 0;
  int          ram_idx    = 0;
  int          ram_err    = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t rom(input word_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic word_t ram_read(input word_t a);
    if (force_load)     return load_cfg;
    if (mem.exists(a))  return mem[a];
    return rom(a);
  endfunction

  // RAM model: per strobe, some waiting cycles (BUSY, optionally one ERROR) then ACCESS.
  initial begin : ram_model
    bus.ramstate = FREE;
    bus.ramload  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.ramREN || bus.ramWEN) begin
        if (!ram_active) begin
          ram_active = 1'b1;
          ram_idx    = 0;
          if (rand_mode) begin
            ram_left = int'($urandom_range(0, 3));
            ram_err  = (ram_left > 0 && $urandom_range(0, 3) == 0) ?
                       int'($urandom_range(0, ram_left - 1)) : -1;
          end else begin
            ram_left = busy_cfg;
            ram_err  = err_cfg;
          end
        end
        if (ram_left == 0) begin
          bus.ramstate = ACCESS;
          if (bus.ramWEN) begin
            mem[bus.ramaddr] = bus.ramstore;
            bus.ramload      = '0;
          end else begin
            bus.ramload = ram_read(bus.ramaddr);
          end
          ram_active = 1'b0;
        end else begin
          bus.ramstate = (ram_idx == ram_err) ? ERROR : BUSY;
          bus.ramload  = '0;
          ram_left--;
          ram_idx++;
        end
      end else begin
        ram_active   = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = '0;
      end
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard pop on each completion.
  initial begin : monitor
    i_txn_t ie;
    d_txn_t de;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        check("rst_iwait",  32'(bus.iwait),  32'd1);
        check("rst_dwait",  32'(bus.dwait),  32'd1);
        check("rst_strobe", 32'(bus.ramREN | bus.ramWEN), 32'd0);
        check("rst_loads",  bus.iload | bus.dload, 32'd0);
      end else begin
        check("one_strobe", 32'(bus.ramREN & bus.ramWEN), 32'd0);
        check("one_done",   32'(!bus.iwait && !bus.dwait), 32'd0);
        if (bus.iwait) check("iload_idle", bus.iload, 32'd0);
        if (bus.dwait) check("dload_idle", bus.dload, 32'd0);
        if (!bus.iREN) check("iwait_noreq", 32'(bus.iwait), 32'd1);
        if (!(bus.dREN || bus.dWEN)) check("dwait_noreq", 32'(bus.dwait), 32'd1);

        if (!bus.iwait && bus.iREN) begin
          check("i_expected", 32'(i_q.size() != 0), 32'd1);
          if (i_q.size() != 0) begin
            ie = i_q.pop_front();
            check("iload",    bus.iload,   ie.data);
            check("i_ramaddr", bus.ramaddr, ie.addr);
            check("i_ramREN", 32'(bus.ramREN), 32'd1);
          end
          order_log.push_back("I");
          i_done_cyc = cyc;
        end

        if (!bus.dwait && (bus.dREN || bus.dWEN)) begin
          check("d_expected", 32'(d_q.size() != 0), 32'd1);
          if (d_q.size() != 0) begin
            de = d_q.pop_front();
            check("d_ramaddr", bus.ramaddr, de.addr);
            if (de.wr) begin
              check("d_ramWEN",   32'(bus.ramWEN), 32'd1);
              check("d_ramstore", bus.ramstore,    de.data);
            end else begin
              check("d_ramREN", 32'(bus.ramREN), 32'd1);
              check("dload",    bus.dload,       de.data);
            end
          end
          order_log.push_back("D");
          d_done_cyc = cyc;
        end
      end
    end
  end

  // Drivers are entered #1 after a rising edge and return at the same phase.
  task automatic do_i(input word_t a, input word_t exp);
    int n = 0;
    i_q.push_back('{addr: a, data: exp});
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    do begin
      @(negedge CLK);
      n++;
    end while (bus.iwait && n < 200);
    if (bus.iwait) check("i_timeout", 32'(bus.iwait), 32'd0);
    @(posedge CLK);
    #1;
    bus.iREN = 1'b0;
  endtask

  task automatic do_d(input logic wr, input word_t a, input word_t data);
    d_txn_t t;
    int n = 0;
    t.wr   = wr;
    t.addr = a;
    if (wr) begin
      t.data    = data;
      shadow[a] = data;
    end else begin
      t.data = shadow.exists(a) ? shadow[a] : rom(a);
    end
    d_q.push_back(t);
    bus.dREN   = !wr;
    bus.dWEN   = wr;
    bus.daddr  = a;
    bus.dstore = wr ? data : word_t'($urandom);
    do begin
      @(negedge CLK);
      n++;
    end while (bus.dwait && n < 200);
    if (bus.dwait) check("d_timeout", 32'(bus.dwait), 32'd0);
    @(posedge CLK);
    #1;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST     = 1'b0;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    order_log.delete();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin : stimulus
    int    c0;
    word_t a;
    logic [7:0] exp_order [4];
    exp_order = '{"D", "I", "D", "I"};

    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN  = 1'b0; bus.daddr = '0; bus.dstore = '0;
    do_reset();

    // Single icache read: two BUSY cycles, completion on cycle 3.
    busy_cfg = 2; err_cfg = -1; force_load = 1'b1; load_cfg = 32'hDEAD_BEEF;
    c0 = cyc;
    fork
      do_i(32'h40, 32'hDEAD_BEEF);
      begin
        @(negedge CLK);
        check("r33_c0_ramREN", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("r33_c1_ramREN",  32'(bus.ramREN), 32'd1);
        check("r33_c1_ramaddr", bus.ramaddr, 32'h40);
        @(negedge CLK);
        check("r33_c2_iwait",   32'(bus.iwait), 32'd1);
        check("r33_c2_ramaddr", bus.ramaddr, 32'h40);
      end
    join
    check("r33_done_cycle", 32'(i_done_cyc), 32'(c0 + 3));
    force_load = 1'b0;

    // Simultaneous requests after reset: dcache write wins, icache follows.
    do_reset();
    busy_cfg = 1;
    fork
      do_i(32'h200, rom(32'h200));
      do_d(1'b1, 32'h80, 32'h1234);
      begin
        @(negedge CLK);
        @(negedge CLK);
        check("r34_ramWEN",   32'(bus.ramWEN), 32'd1);
        check("r34_ramREN",   32'(bus.ramREN), 32'd0);
        check("r34_ramaddr",  bus.ramaddr,  32'h80);
        check("r34_ramstore", bus.ramstore, 32'h1234);
      end
    join
    check("r34_count",  32'(order_log.size()), 32'd2);
    check("r34_first",  32'(order_log[0]), 32'(8'("D")));
    check("r34_second", 32'(order_log[1]), 32'(8'("I")));

    // Both requesting back-to-back: grants alternate D, I, D, I.
    do_reset();
    busy_cfg = 0;
    fork
      repeat (2) do_d(1'b0, 32'h84, 32'h0);
      repeat (2) do_i(32'h204, rom(32'h204));
    join
    check("r35_count", 32'(order_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("r35_order%0d", k),
                                      32'(order_log[k]), 32'(exp_order[k]));

    // One ERROR while granted to the icache: retried with the same address.
    do_reset();
    busy_cfg = 3; err_cfg = 1;
    c0 = cyc;
    fork
      do_i(32'h300, rom(32'h300));
      begin
        @(negedge CLK);
        for (int k = 1; k <= 3; k++) begin
          @(negedge CLK);
          check($sformatf("r36_c%0d_ramaddr", k), bus.ramaddr, 32'h300);
          check($sformatf("r36_c%0d_iwait", k),   32'(bus.iwait), 32'd1);
          check($sformatf("r36_c%0d_ramREN", k),  32'(bus.ramREN), 32'd1);
        end
      end
    join
    check("r36_done_cycle", 32'(i_done_cyc), 32'(c0 + 4));
    err_cfg = -1;

    // dcache read abandoned while BUSY; the waiting icache read is granted next.
    do_reset();
    busy_cfg = 5;
    fork
      do_i(32'h100, rom(32'h100));
      begin
        bus.dREN  = 1'b1;
        bus.daddr = 32'h90;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("r37_c1_ramREN",  32'(bus.ramREN), 32'd1);
        check("r37_c1_ramaddr", bus.ramaddr, 32'h90);
        @(posedge CLK); #1;
        bus.dREN = 1'b0;
        @(negedge CLK);
        check("r37_c2_dwait", 32'(bus.dwait), 32'd1);
        @(negedge CLK);
        check("r37_c3_strobes", 32'(bus.ramREN | bus.ramWEN), 32'd0);
        @(negedge CLK);
        check("r37_c4_ramREN",  32'(bus.ramREN), 32'd1);
        check("r37_c4_ramaddr", bus.ramaddr, 32'h100);
      end
    join
    check("r37_count", 32'(order_log.size()), 32'd1);
    check("r37_only_i", 32'(order_log[0]), 32'(8'("I")));

    // Reset in the middle of a dcache write.
    do_reset();
    busy_cfg = 5;
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'hC0;
    bus.dstore = 32'h5555;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("r32_pre_ramWEN", 32'(bus.ramWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("r32_async_ramWEN",   32'(bus.ramWEN), 32'd0);
    check("r32_async_dwait",    32'(bus.dwait), 32'd1);
    check("r32_async_ramaddr",  bus.ramaddr,  32'd0);
    check("r32_async_ramstore", bus.ramstore, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("r32_next_ramWEN", 32'(bus.ramWEN), 32'd0);
    check("r32_next_dwait",  32'(bus.dwait), 32'd1);
    bus.dWEN = 1'b0;
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("r32_idle_strobes", 32'(bus.ramREN | bus.ramWEN), 32'd0);
    @(posedge CLK); #1;

    // Random traffic from both caches against the random RAM.
    rand_mode = 1'b1;
    fork
      for (int k = 0; k < 40; k++) begin
        word_t ia;
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        ia = 32'h1000 + (word_t'($urandom_range(0, 15)) << 2);
        do_i(ia, rom(ia));
      end
      for (int k = 0; k < 40; k++) begin
        word_t da;
        repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
        da = 32'h80 + (word_t'($urandom_range(0, 7)) << 2);
        do_d(logic'($urandom_range(0, 1)), da, word_t'($urandom));
      end
    join
    a = word_t'(i_q.size() + d_q.size());
    check("scoreboard_drained", a, 32'd0);

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising-edge.
REQ-002 SHALL have ports: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: iREN  in  1  icache read request, held until iwait low.
REQ-004 SHALL have ports: iaddr  in  32  icache word address.
REQ-005 SHALL have ports: iwait  out  1  icache stall, low for exactly the completing cycle.
REQ-006 SHALL have ports: iload  out  32  instruction word, valid when iwait low.
REQ-007 SHALL have ports: dREN  in  1  dcache read request.
REQ-008 SHALL have ports: dWEN  in  1  dcache write request; dREN and dWEN are never both high.
REQ-009 SHALL have ports: daddr  in  32  dcache word address.
REQ-010 SHALL have ports: dstore  in  32  dcache write data.
REQ-011 SHALL have ports: dwait  out  1  dcache stall, low for exactly the completing cycle.
REQ-012 SHALL have ports: dload  out  32  data word, valid when dwait low.
REQ-013 SHALL have ports: ramREN / ramWEN  out  1 each  RAM strobes.
REQ-014 SHALL have ports: ramaddr  out  32  latched RAM address.
REQ-015 SHALL have ports: ramstore  out  32  latched RAM write data.
REQ-016 SHALL have ports: ramload  in  32  RAM read data.
REQ-017 SHALL have ports: ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-018 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-019 IDLE: no request -> stay; only one requester -> grant it; both -> grant D unless last_grant==D, then grant I.
REQ-020 On grant, SHALL latch addr, store data and read/write kind in the same edge; ram* outputs come from latches only.
REQ-021 GRANT_x: ramREN/ramWEN asserted per latched kind; all other ram strobes 0.
REQ-022 GRANT_x with ramstate==ACCESS: xwait=0, xload=ramload (combinational) that cycle; next state IDLE; last_grant<=x.
REQ-023 GRANT_x with ramstate FREE/BUSY/ERROR: xwait=1; stay; ERROR retries with same latched request.
REQ-024 Non-granted requester's wait SHALL be 1 whenever its REN/WEN is high; wait SHALL be 1 when no request exists.
REQ-025 xload SHALL be 0 except in its completing cycle.
REQ-026 Granted requester dropping its strobe before ACCESS: abort; next state IDLE; strobes low next cycle; last_grant unchanged.
REQ-027 Latency: request at cycle 0 in IDLE -> ram strobe at cycle 1 -> earliest completion cycle 1; min two cycles between back-to-back grants.
REQ-028 Back-to-back same requester with other idle SHALL be re-granted without extra stall beyond the IDLE cycle.

Reset
REQ-029 nRST low SHALL force IDLE, last_grant=I, latches 0, all ram strobes 0, iwait=dwait=1, loads 0, immediately, including mid-transaction.

Structure
REQ-030 arb_state_t (IDLE, GRANT_I, GRANT_D) SHALL be added to cpu_types_pkg beside ramstate_t and word_t.
REQ-031 Single module; no sub-module; one sequential block, one next-state block, one output block.

Verification
REQ-032 Reset mid-GRANT_D -> next cycle ramWEN=0, dwait=1, state IDLE.
REQ-033 iREN, iaddr=0x40, ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramaddr=0x40 from cycle 1, iwait low cycle 3, iload=0xDEADBEEF.
REQ-034 iREN and dWEN together, daddr=0x80, dstore=0x1234 -> D granted first, ramWEN, ramstore=0x1234; I granted next, iwait low afterward.
REQ-035 Both requesting continuously for 4 transactions -> grant order D,I,D,I; neither starved.
REQ-036 ERROR once during GRANT_I -> request retried, iwait stays high until ACCESS, address unchanged.
REQ-037 dREN dropped while BUSY -> dwait never low, state IDLE next cycle, pending iREN then granted.
